// File: rtl/i2s_pkg.sv
// Shared widths, the stereo sample layout and channel encoding for the I2S transmitter.
package i2s_pkg;
  localparam int SAMPLE_W_DEF = 16;
  localparam int SLOT_W_DEF   = 32;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;
endpackage

// File: rtl/sample_fifo.sv
// Show-ahead synchronous FIFO: pop data is valid whenever not empty, level is registered.
// Push while full and pop while empty are ignored; DEPTH must be a power of 2.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_pop_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// I2S slave transmitter: codec SCLK/LRCLK oversampled in the Clk domain, {L,R} words from a FIFO.
// Optional I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun counter (underrun_count, cnt_clr).
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int DEPTH    = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    sclk_in,
  input  logic                    lrclk_in,
  input  logic                    wr_valid,
  input  logic [2*SAMPLE_W-1:0]   wr_data,
  output logic                    wr_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  input  logic                    mute,
  output logic                    sdout,
  output logic                    frame_start,
  output logic                    underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  input  logic                    cnt_clr,
  output logic [15:0]             underrun_count
`endif
);
  localparam int CW = $clog2(SLOT_W);

  logic [1:0]            r_sclk_sync;
  logic [1:0]            r_lr_sync;
  logic                  r_sclk_prev;
  channel_e              r_lr_cur;
  logic                  r_load_pending;
  logic [CW-1:0]         r_bit_cnt;
  logic [SAMPLE_W-1:0]   r_shift;
  logic [SAMPLE_W-1:0]   r_hold_r;
  logic                  r_sdout;
  logic                  r_frame_start;
  logic                  r_underrun;

  logic                  w_sclk_s;
  channel_e              w_lrclk_s;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_load;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [2*SAMPLE_W-1:0] w_fifo_dat;
  logic [SAMPLE_W-1:0]   w_word;
  logic [SAMPLE_W-1:0]   w_shift;

  assign w_sclk_s  = r_sclk_sync[1];
  assign w_lrclk_s = channel_e'(r_lr_sync[1]);
  assign w_rise    = w_sclk_s & ~r_sclk_prev;
  assign w_fall    = ~w_sclk_s & r_sclk_prev;
  assign w_load    = w_fall & r_load_pending;
  assign w_pop     = w_load & (r_lr_cur == CH_LEFT);
  assign w_push    = wr_valid & wr_ready;
  assign wr_ready  = ~w_fifo_full;
  assign w_shift   = {r_shift[SAMPLE_W-2:0], 1'b0};

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (2*SAMPLE_W)
  ) u_fifo (
    .i_clk      (Clk),
    .i_reset    (Reset),
    .i_push     (w_push),
    .i_push_dat (wr_data),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_level    (fifo_level)
  );

  // Only the right half needs holding: the left half goes straight into the shifter.
  always_comb begin
    w_word = '0;
    if (r_lr_cur == CH_LEFT) begin
      if (!w_fifo_empty) w_word = w_fifo_dat[2*SAMPLE_W-1:SAMPLE_W];
    end else begin
      w_word = r_hold_r;
    end
    if (mute) w_word = '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sclk_sync    <= '0;
      r_lr_sync      <= '0;
      r_sclk_prev    <= 1'b0;
      r_lr_cur       <= CH_LEFT;
      r_load_pending <= 1'b0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_hold_r       <= '0;
      r_sdout        <= 1'b0;
      r_frame_start  <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[0], sclk_in};
      r_lr_sync     <= {r_lr_sync[0], lrclk_in};
      r_sclk_prev   <= w_sclk_s;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;

      if (w_rise) begin
        r_lr_cur <= w_lrclk_s;
        if (w_lrclk_s != r_lr_cur) r_load_pending <= 1'b1;
      end

      if (w_load) begin
        r_load_pending <= 1'b0;
        r_bit_cnt      <= '0;
        r_shift        <= w_word;
        r_sdout        <= w_word[SAMPLE_W-1];
        if (r_lr_cur == CH_LEFT) begin
          r_frame_start <= 1'b1;
          if (w_fifo_empty) begin
            r_hold_r   <= '0;
            r_underrun <= 1'b1;
          end else begin
            r_hold_r   <= w_fifo_dat[SAMPLE_W-1:0];
          end
        end
      end else if (w_fall) begin
        r_shift <= w_shift;
        if (r_bit_cnt != CW'(SLOT_W - 1)) r_bit_cnt <= r_bit_cnt + CW'(1);
        r_sdout <= (int'(r_bit_cnt) + 1 < SAMPLE_W) ? w_shift[SAMPLE_W-1] : 1'b0;
      end
    end
  end

  assign sdout       = r_sdout;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_ur_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || cnt_clr)                     r_ur_cnt <= '0;
    else if (r_underrun && r_ur_cnt != 16'hFFFF) r_ur_cnt <= r_ur_cnt + 16'd1;
  end

  assign underrun_count = r_ur_cnt;
`endif
endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: a codec model drives SCLK/LRCLK, frames are captured at SCLK rises.
module tb_i2s_tx;
  import i2s_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sclk = 1'b0;
  logic        lrclk = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic [2:0]  fifo_level;
  logic        mute = 1'b0;
  logic        sdout;
  logic        frame_start;
  logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] underrun_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int fs_cnt = 0;
  int ur_cnt = 0;
  int ur_hi = 0;
  logic ur_prev = 1'b0;
  logic [63:0] exp_q[$];

  i2s_tx dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .sclk_in     (sclk),
    .lrclk_in    (lrclk),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .fifo_level  (fifo_level),
    .mute        (mute),
    .sdout       (sdout),
    .frame_start (frame_start),
    .underrun    (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .cnt_clr        (cnt_clr),
    .underrun_count (underrun_count)
`endif
  );

  always #5 Clk = ~Clk;

  // Codec master: SCLK half-period 16 Clk, LRCLK toggles on SCLK falls every 32 SCLK.
  initial begin
    int fall_n;
    fall_n = 0;
    forever begin
      repeat (16) @(negedge Clk);
      sclk = 1'b1;
      repeat (16) @(negedge Clk);
      sclk = 1'b0;
      if (fall_n == 0)  lrclk = 1'b0;
      if (fall_n == 32) lrclk = 1'b1;
      fall_n = (fall_n + 1) % 64;
    end
  end

  always @(negedge Clk) begin
    if (frame_start) fs_cnt = fs_cnt + 1;
    if (underrun) ur_hi = ur_hi + 1;
    if (underrun && !ur_prev) ur_cnt = ur_cnt + 1;
    ur_prev = underrun;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] frame_of(input logic [31:0] w, input bit m);
    stereo_sample_t s;
    s = stereo_sample_t'(w);
    return m ? 64'h0 : {s.left, 16'h0, s.right, 16'h0};
  endfunction

  task automatic push_word(input logic [31:0] w);
    wr_data  = w;
    wr_valid = 1'b1;
    @(negedge Clk);
    wr_valid = 1'b0;
  endtask

  task automatic sync_mid;
    @(negedge lrclk);
    repeat (4) @(posedge sclk);
  endtask

  // Samples R1..R63 after the LRCLK fall; the 64th bit (right slot padding) lands after the next fall.
  task automatic capture_frame(output logic [63:0] got, output logic [63:0] exp, output bit have);
    got = '0;
    @(negedge lrclk);
    @(posedge sclk);
    for (int i = 0; i < 63; i++) begin
      @(posedge sclk);
      got[63-i] = sdout;
    end
    have = (exp_q.size() > 0);
    exp  = have ? exp_q.pop_front() : 64'h0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    n_vec += 5;
    if (sdout !== 1'b0)        begin n_err++; $display("FAIL reset_sdout got %b want 0", sdout); end
    if (frame_start !== 1'b0)  begin n_err++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    if (underrun !== 1'b0)     begin n_err++; $display("FAIL reset_underrun got %b want 0", underrun); end
    if (fifo_level !== 3'd0)   begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    if (wr_ready !== 1'b1)     begin n_err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    n_vec++;
    if (underrun_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", underrun_count); end
`endif
    Reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [63:0] got, exp;
    bit have;
    int fs0, ur0;
    sync_mid;
    push_word(32'hA5F0_0F5A);
    exp_q.push_back(frame_of(32'hA5F0_0F5A, 1'b0));
    fs0 = fs_cnt; ur0 = ur_cnt;
    capture_frame(got, exp, have);
    n_vec += 3;
    if (!have || got !== exp) begin n_err++; $display("FAIL basic_frame got %h want %h", got, exp); end
    if (fs_cnt - fs0 != 1) begin n_err++; $display("FAIL basic_frame_start got %0d pulses want 1", fs_cnt - fs0); end
    if (ur_cnt - ur0 != 0) begin n_err++; $display("FAIL basic_underrun got %0d pulses want 0", ur_cnt - ur0); end
  endtask

  task automatic test_underrun;
    logic [63:0] got, exp;
    bit have;
    int ur0, hi0;
    sync_mid;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    cnt_clr = 1'b1;
    @(negedge Clk);
    cnt_clr = 1'b0;
    n_vec++;
    if (underrun_count !== 16'd0) begin n_err++; $display("FAIL cnt_clr got %0d want 0", underrun_count); end
`endif
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    ur0 = ur_cnt; hi0 = ur_hi;
    capture_frame(got, exp, have);
    n_vec += 3;
    if (!have || got !== exp) begin n_err++; $display("FAIL underrun_frame got %h want %h", got, exp); end
    if (ur_cnt - ur0 != 1) begin n_err++; $display("FAIL underrun_pulses got %0d want 1", ur_cnt - ur0); end
    if (ur_hi - hi0 != 1) begin n_err++; $display("FAIL underrun_width got %0d cycles want 1", ur_hi - hi0); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    n_vec++;
    if (underrun_count !== 16'd1) begin n_err++; $display("FAIL underrun_count1 got %0d want 1", underrun_count); end
`endif
    capture_frame(got, exp, have);
    n_vec++;
    if (!have || got !== exp) begin n_err++; $display("FAIL underrun_frame2 got %h want %h", got, exp); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    n_vec++;
    if (underrun_count !== 16'd2) begin n_err++; $display("FAIL underrun_count2 got %0d want 2", underrun_count); end
`endif
  endtask

  task automatic test_full;
    logic [63:0] got, exp;
    bit have;
    logic [31:0] w;
    sync_mid;
    for (int i = 0; i < 5; i++) begin
      w = {16'h1111 * 16'(i + 1), ~(16'h1111 * 16'(i + 1))};
      n_vec++;
      if (wr_ready !== (i < 4)) begin n_err++; $display("FAIL full_ready_%0d got %b want %b", i, wr_ready, (i < 4)); end
      if (i < 4) exp_q.push_back(frame_of(w, 1'b0));
      wr_data  = w;
      wr_valid = 1'b1;
      @(negedge Clk);
    end
    wr_valid = 1'b0;
    n_vec++;
    if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level got %0d want 4", fifo_level); end
    capture_frame(got, exp, have);
    n_vec += 3;
    if (!have || got !== exp) begin n_err++; $display("FAIL full_frame0 got %h want %h", got, exp); end
    if (fifo_level !== 3'd3) begin n_err++; $display("FAIL full_level_after got %0d want 3", fifo_level); end
    if (wr_ready !== 1'b1)   begin n_err++; $display("FAIL full_ready_after got %b want 1", wr_ready); end
    for (int f = 1; f < 4; f++) begin
      capture_frame(got, exp, have);
      n_vec++;
      if (!have || got !== exp) begin n_err++; $display("FAIL full_frame%0d got %h want %h", f, got, exp); end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] got, exp;
    bit have;
    logic [31:0] z;
    sync_mid;
    push_word(32'hFFFF_1234);
    push_word(32'h8001_8001);
    @(negedge lrclk);
    repeat (9) @(posedge sclk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    n_vec += 2;
    if (sdout !== 1'b0)      begin n_err++; $display("FAIL rst_mid_sdout got %b want 0", sdout); end
    if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_mid_level got %0d want 0", fifo_level); end
    z = $urandom;
    push_word(z);
    exp_q.push_back(frame_of(z, 1'b0));
    capture_frame(got, exp, have);
    n_vec++;
    if (!have || got !== exp) begin n_err++; $display("FAIL rst_mid_frame got %h want %h", got, exp); end
  endtask

  task automatic test_mute;
    logic [63:0] got, exp;
    bit have;
    int ur0;
    sync_mid;
    mute = 1'b1;
    push_word(32'h7FFF_8000);
    push_word(32'hDEAD_BEEF);
    exp_q.push_back(frame_of(32'h7FFF_8000, 1'b1));
    exp_q.push_back(frame_of(32'hDEAD_BEEF, 1'b1));
    ur0 = ur_cnt;
    n_vec++;
    if (fifo_level !== 3'd2) begin n_err++; $display("FAIL mute_level2 got %0d want 2", fifo_level); end
    capture_frame(got, exp, have);
    n_vec += 2;
    if (!have || got !== exp) begin n_err++; $display("FAIL mute_frame0 got %h want %h", got, exp); end
    if (fifo_level !== 3'd1)  begin n_err++; $display("FAIL mute_level1 got %0d want 1", fifo_level); end
    capture_frame(got, exp, have);
    n_vec += 3;
    if (!have || got !== exp) begin n_err++; $display("FAIL mute_frame1 got %h want %h", got, exp); end
    if (fifo_level !== 3'd0)  begin n_err++; $display("FAIL mute_level0 got %0d want 0", fifo_level); end
    if (ur_cnt != ur0)        begin n_err++; $display("FAIL mute_underrun got %0d pulses want 0", ur_cnt - ur0); end
    mute = 1'b0;
  endtask

  task automatic test_push_during_underrun;
    logic [63:0] got, exp;
    bit have;
    int ur0;
    sync_mid;
    ur0 = ur_cnt;
    // Load fires on the 3rd Clk edge after the SCLK fall; push lands on that same edge.
    @(negedge lrclk);
    @(negedge sclk);
    repeat (2) @(negedge Clk);
    wr_data  = 32'h1357_9BDF;
    wr_valid = 1'b1;
    @(negedge Clk);
    wr_valid = 1'b0;
    repeat (4) @(posedge sclk);
    n_vec += 2;
    if (ur_cnt - ur0 != 1)   begin n_err++; $display("FAIL pdu_underrun got %0d pulses want 1", ur_cnt - ur0); end
    if (fifo_level !== 3'd1) begin n_err++; $display("FAIL pdu_level got %0d want 1", fifo_level); end
    exp_q.push_back(frame_of(32'h1357_9BDF, 1'b0));
    capture_frame(got, exp, have);
    n_vec++;
    if (!have || got !== exp) begin n_err++; $display("FAIL pdu_frame got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underrun;
    test_full;
    test_reset_mid;
    test_mute;
    test_push_during_underrun;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serialises stereo PCM samples onto the I2S data line (ARDUINO_IO[1]) feeding the codec.
- The codec is clock master. It drives SCLK (ARDUINO_IO[5]) and LRCLK (ARDUINO_IO[4]); this block samples both asynchronously in the 50 MHz domain.
- Upstream, a sample source such as the ROM reader or the Nios path pushes {left,right} words into a small internal FIFO.
- Replaces ad-hoc clocking of logic on SCLK with a single-clock design.

Parameters:
- SAMPLE_W, 16, bits per channel sample (MSB-first, two's complement).
- SLOT_W, 32, SCLK periods per LRCLK half. Bits after SAMPLE_W are driven 0.
- DEPTH, 4, FIFO entries. Must be a power of 2, at least 2.

Ports:
- Clk  in  1  MAX10_CLK1_50 system clock.
- Reset  in  1  synchronous, active-high.
- sclk_in  in  1  codec bit clock, asynchronous.
- lrclk_in  in  1  codec word clock, asynchronous. 0 = left, 1 = right.
- wr_valid  in  1  upstream sample valid.
- wr_data  in  2*SAMPLE_W  {left[MSB half], right[LSB half]}.
- wr_ready  out  1  FIFO not full. Push occurs when wr_valid && wr_ready.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- mute  in  1  force transmitted words to 0. FIFO still drains.
- sdout  out  1  I2S serial data to the codec.
- frame_start  out  1  one-Clk pulse when a left word is loaded.
- underrun  out  1  one-Clk pulse when a frame finds the FIFO empty.

Behaviour:
- Synchronisers:
  - sclk_in and lrclk_in each pass through 2 flops, then 1 history flop.
  - sclk_rise = prev 0, now 1. sclk_fall = prev 1, now 0. Each is a single-Clk strobe.
  - Latency from pad to strobe is 3 Clk. Requires SCLK half-period of at least 4 Clk.
- On sclk_rise:
  - lr_cur <= lrclk_s.
  - If lr_cur differs from its previous value, set load_pending.
- On sclk_fall with load_pending, load the word:
  - Clear load_pending and set bit_cnt = 0.
  - If lr_cur = 0 (left), pop the FIFO into hold{L,R}, pulse frame_start, and load L into the shifter.
  - If the FIFO is empty at that pop, hold <= 0, pulse underrun and load 0.
  - If lr_cur = 1 (right), load hold.R. No pop.
  - If mute = 1, the loaded word is 0. The pop still occurs.
  - sdout <= shifter MSB.
- Net effect: MSB appears one SCLK after the LRCLK edge (standard I2S delay).
- On sclk_fall without load_pending:
  - Shift left and bit_cnt++.
  - sdout <= next bit while bit_cnt < SAMPLE_W, else 0.
  - bit_cnt saturates at SLOT_W-1.
- An LRCLK half shorter than SAMPLE_W truncates the word; the next word loads normally.
- FIFO:
  - wr_ready = (level != DEPTH).
  - Push and pop in the same Clk:
    - Not empty and not full: level unchanged, both occur.
    - Full: push blocked by wr_ready, pop occurs.
    - Empty: pop underruns, push lands, level becomes 1.
  - Pointers wrap modulo DEPTH.
- Reset values:
  - sdout = 0, frame_start = 0, underrun = 0, fifo_level = 0, wr_ready = 1.
  - hold = 0, shifter = 0, load_pending = 0, bit_cnt = 0.
  - Synchroniser, history and lr_cur flops = 0.
- Reset mid-word:
  - sdout = 0 from the next Clk and the FIFO is discarded.
  - Transmission resumes at the next LRCLK edge seen after Reset deasserts. The first left load pops normally.
- Start-up: after Reset, lrclk_s passes through 0 for 2-3 Clk before tracking lrclk_in.
  - If LRCLK is high at Reset release, the first observed change is 0→1 and a right load of hold.R = 0 occurs.
  - If LRCLK is low at Reset release, nothing loads until the next LRCLK edge.

Optional Feature:
- I2S_TX_UNDERRUN_CNT_EN defined:
  - Adds output underrun_count [15:0].
  - Increments on every underrun pulse and saturates at 16'hFFFF.
  - Clears on Reset or on input cnt_clr (1-bit, same Clk). cnt_clr wins over a simultaneous increment.
- Undefined: neither port nor counter exists.

Decomposition:
- Package i2s_pkg holds:
  - SAMPLE_W and SLOT_W defaults.
  - typedef stereo_sample_t (packed struct: left, right of SAMPLE_W).
  - Channel enum CH_LEFT = 0, CH_RIGHT = 1.
- Sub-module sample_fifo: synchronous FIFO, DEPTH, width 2*SAMPLE_W, ports push/pop/full/empty/level.
- Serialiser, synchronisers and edge detection stay in i2s_tx.

Test Plan:
- Bench clocking: SCLK half-period 16 Clk; 32 SCLK per LRCLK half.
- Push {16'hA5F0,16'h0F5A}, then LRCLK 1→0 → sampled at successive SCLK rises:
  - left slot: sdout = 1010010111110000, then 16 zeros;
  - after LRCLK 0→1, right slot: sdout = 0000111101011010, then 16 zeros;
  - frame_start pulses once.
- Empty FIFO at LRCLK fall → left and right slots all 0, underrun pulses exactly 1 Clk. With the macro, underrun_count = 1, and 2 after the next empty frame.
- Push 5 words back-to-back with wr_valid held → wr_ready drops after the 4th, fifo_level = 4, 5th not accepted. After one left load: level = 3, wr_ready = 1.
- Assert Reset for 1 Clk at bit 7 of a left word → sdout = 0 next Clk, fifo_level = 0. The next LRCLK fall with a new pushed word transmits it intact.
- mute = 1 with 2 queued words over 2 frames → sdout all 0, fifo_level 2→1→0, no underrun pulse.
- Push during an underrun pop with the FIFO empty → underrun pulses, fifo_level = 1, and the next frame transmits the pushed word.
